// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/data memory port arbiter: FSM states, owner
// codes and default tuning constants.
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY_I = 2'd1;
   localparam logic [1:0] ST_BUSY_D = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   localparam int DEF_STARVE_LIMIT = 4;
   localparam int DEF_TIMEOUT      = 64;
   localparam int STARVE_W         = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Grant decision for the shared port: data wins by default, IF is forced
// through once it has lost STARVE_LIMIT consecutive contended arbitrations.
module arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic                d_req,
   input  logic                idle,
   output logic                grant_if,
   output logic                grant_d,
   output logic [STARVE_W-1:0] starve_cnt
);

   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

   logic [STARVE_W-1:0] cnt_reg, cnt_next;
   logic                force_if;

   assign force_if = if_req && d_req && (cnt_reg == LIMIT);

   always_comb begin
      grant_d  = idle && d_req && !force_if;
      grant_if = idle && if_req && !grant_d;
      cnt_next = cnt_reg;
      if (grant_if)
         cnt_next = '0;
      else if (grant_d && if_req && (cnt_reg != LIMIT))
         cnt_next = cnt_reg + STARVE_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end

   assign starve_cnt = cnt_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and the data
// stage, with a valid/ack handshake toward memory and a sticky watchdog.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              timeout_err
);

   localparam int              WD_W   = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_SET = WD_W'(TIMEOUT - 2);
   localparam logic [WD_W-1:0] WD_MAX = '1;

   logic [1:0]          state_reg, state_next;
   logic                owner_reg, we_reg, timeout_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg, if_rdata_reg, d_rdata_reg;
   logic [WD_W-1:0]     wd_cnt_reg;
   logic                idle, in_busy, grant_if, grant_d;
   logic [STARVE_W-1:0] starve_cnt;
   logic                unused_ok;

   assign idle    = (state_reg == ST_IDLE);
   assign in_busy = (state_reg == ST_BUSY_I) || (state_reg == ST_BUSY_D);

   arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .d_req      (d_req),
      .idle       (idle),
      .grant_if   (grant_if),
      .grant_d    (grant_d),
      .starve_cnt (starve_cnt)
   );

   // Starvation count is kept visible for debug only.
   assign unused_ok = ^starve_cnt;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (grant_d)
               state_next = ST_BUSY_D;
            else if (grant_if)
               state_next = ST_BUSY_I;
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (mem_ack)
               state_next = ST_RESP;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         owner_reg    <= OWN_IF;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         if_rdata_reg <= '0;
         d_rdata_reg  <= '0;
         wd_cnt_reg   <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (idle && (grant_if || grant_d)) begin
            owner_reg  <= grant_d ? OWN_D : OWN_IF;
            we_reg     <= grant_d && d_we;
            addr_reg   <= grant_d ? d_addr : if_addr;
            wdata_reg  <= grant_d ? d_wdata : '0;
            wd_cnt_reg <= '0;
         end
         if (in_busy) begin
            if (mem_ack) begin
               if (owner_reg == OWN_IF)
                  if_rdata_reg <= mem_rdata;
               else if (!we_reg)
                  d_rdata_reg <= mem_rdata;
            end else begin
               if (wd_cnt_reg != WD_MAX)
                  wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
               // Flag becomes visible in the TIMEOUT-th cycle spent waiting.
               if (wd_cnt_reg == WD_SET)
                  timeout_reg <= 1'b1;
            end
         end
      end
   end

   assign mem_valid   = in_busy;
   assign mem_we      = we_reg;
   assign mem_addr    = addr_reg;
   assign mem_wdata   = wdata_reg;
   assign if_rdata    = if_rdata_reg;
   assign d_rdata     = d_rdata_reg;
   assign if_done     = (state_reg == ST_RESP) && (owner_reg == OWN_IF);
   assign d_done      = (state_reg == ST_RESP) && (owner_reg == OWN_D);
   assign busy        = !idle;
   assign timeout_err = timeout_reg;

endmodule
